// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: handshaked RV32I ALU/branch unit, 1-cycle ops plus optional iterative RV32M.
// Define SEQ_ALU_MULDIV_EN to build the multiply/divide datapath and CALC state.
module seq_alu_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_sel,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            br_taken,
  output logic            illegal
);
  localparam int unsigned SHAMT = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_BR   = 4'b0010;
  localparam logic [3:0] OP_JMP  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LUI  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1101;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state, state_d;
  logic              out_valid_d, br_d, ill_d;
  logic [XLEN-1:0]   result_d;
  logic [XLEN-1:0]   alu_res;
  logic              alu_br, alu_ill;
  logic [SHAMT-1:0]  shamt;
  logic              accept;

  assign shamt    = b[SHAMT-1:0];
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle ALU / branch evaluation
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    alu_ill = 1'b0;
    case (alu_sel)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = XLEN'($signed(a) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
      OP_LUI:  alu_res = b << 12;
      OP_JMP: begin
        alu_br  = 1'b1;
        alu_res = a + b;
      end
      OP_BR: begin
        case (func3)
          3'b000:  alu_br = (a == b);
          3'b001:  alu_br = (a != b);
          3'b100:  alu_br = $signed(a) < $signed(b);
          3'b101:  alu_br = $signed(a) >= $signed(b);
          3'b110:  alu_br = a < b;
          3'b111:  alu_br = a >= b;
          default: alu_ill = 1'b1;
        endcase
      end
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  localparam logic [3:0]      OP_MD = 4'b1100;
  localparam logic [XLEN-1:0] SMIN  = {1'b1, {(XLEN-1){1'b0}}};

  // p holds {hi, lo} for multiply and {remainder, dividend/quotient} for divide
  logic [2*XLEN-1:0] p, p_d, p_step, full;
  logic [XLEN-1:0]   opb, opb_d, mag_a, mag_b, q_fix, r_fix, md_res, spec_res;
  logic [SHAMT-1:0]  cnt, cnt_d;
  logic [2:0]        md_f3, md_f3_d;
  logic              neg_q, neg_q_d, neg_r, neg_r_d;
  logic              neg_a_in, neg_b_in, spec;
  logic [XLEN:0]     mul_sum, r_sh, diff;

  // Operand magnitudes and the single-cycle divide corner cases
  always_comb begin
    neg_a_in = a[XLEN-1] && (func3 inside {3'b001, 3'b010, 3'b100, 3'b110});
    neg_b_in = b[XLEN-1] && (func3 inside {3'b001, 3'b100, 3'b110});
    mag_a    = neg_a_in ? -a : a;
    mag_b    = neg_b_in ? -b : b;
    spec     = func3[2] && ((b == '0) || (!func3[0] && (a == SMIN) && (b == '1)));
    if (b == '0) spec_res = func3[1] ? a : '1;
    else         spec_res = func3[1] ? '0 : a;
  end

  // One radix-2 iteration plus the sign fixup applied on the final iteration
  always_comb begin
    mul_sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
    r_sh    = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    diff    = r_sh - {1'b0, opb};
    if (!md_f3[2])      p_step = {mul_sum, p[XLEN-1:1]};
    else if (!diff[XLEN]) p_step = {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
    else                p_step = {r_sh[XLEN-1:0], p[XLEN-2:0], 1'b0};
    full  = neg_q ? -p_step : p_step;
    q_fix = neg_q ? -p_step[XLEN-1:0] : p_step[XLEN-1:0];
    r_fix = neg_r ? -p_step[2*XLEN-1:XLEN] : p_step[2*XLEN-1:XLEN];
    case (md_f3)
      3'b000:                 md_res = full[XLEN-1:0];
      3'b001, 3'b010, 3'b011: md_res = full[2*XLEN-1:XLEN];
      3'b100, 3'b101:         md_res = q_fix;
      default:                md_res = r_fix;
    endcase
  end
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state;
    out_valid_d = out_valid;
    result_d    = result;
    br_d        = br_taken;
    ill_d       = illegal;
`ifdef SEQ_ALU_MULDIV_EN
    p_d         = p;
    opb_d       = opb;
    cnt_d       = cnt;
    md_f3_d     = md_f3;
    neg_q_d     = neg_q;
    neg_r_d     = neg_r;
`endif
    case (state)
      IDLE, DONE: begin
        if ((state == DONE) && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
        if (accept) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = alu_res;
          br_d        = alu_br;
          ill_d       = alu_ill;
`ifdef SEQ_ALU_MULDIV_EN
          if (alu_sel == OP_MD) begin
            br_d  = 1'b0;
            ill_d = 1'b0;
            if (spec) begin
              result_d = spec_res;
            end else begin
              state_d     = CALC;
              out_valid_d = 1'b0;
              p_d         = {{XLEN{1'b0}}, mag_a};
              opb_d       = mag_b;
              cnt_d       = '0;
              md_f3_d     = func3;
              neg_q_d     = neg_a_in ^ neg_b_in;
              neg_r_d     = neg_a_in;
            end
          end
`endif
        end
      end
`ifdef SEQ_ALU_MULDIV_EN
      CALC: begin
        p_d   = p_step;
        cnt_d = cnt + SHAMT'(1);
        if (cnt == SHAMT'(XLEN-1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = md_res;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      br_taken  <= 1'b0;
      illegal   <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
      p         <= '0;
      opb       <= '0;
      cnt       <= '0;
      md_f3     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      out_valid <= out_valid_d;
      result    <= result_d;
      br_taken  <= br_d;
      illegal   <= ill_d;
`ifdef SEQ_ALU_MULDIV_EN
      p         <= p_d;
      opb       <= opb_d;
      cnt       <= cnt_d;
      md_f3     <= md_f3_d;
      neg_q     <= neg_q_d;
      neg_r     <= neg_r_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_alu_muldiv.sv
// Directed bench for seq_alu_muldiv at XLEN=32 and XLEN=16; MULDIV expectations follow SEQ_ALU_MULDIV_EN.
module tb_seq_alu_muldiv;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, br_taken, illegal;
  logic [3:0]  alu_sel;
  logic [2:0]  func3;
  logic [31:0] a, b, result;
  logic        iv16, rdy16, ov16, br16, ill16;
  logic [15:0] a16, b16, r16;

  int checks = 0;
  int errors = 0;

  seq_alu_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_sel(alu_sel), .func3(func3), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .br_taken(br_taken), .illegal(illegal)
  );

  seq_alu_muldiv #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16),
    .alu_sel(alu_sel), .func3(func3), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(out_ready), .result(r16),
    .br_taken(br16), .illegal(ill16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one op to the 32-bit unit, wait for out_valid, check latency and outputs
  task automatic op(input string tag, input logic [3:0] sel, input logic [2:0] f3,
                    input logic [31:0] aa, input logic [31:0] bb, input logic [31:0] eres,
                    input logic ebr, input logic eill, input int elat);
    int lat;
    alu_sel = sel; func3 = f3; a = aa; b = bb; in_valid = 1'b1;
    #1;
    chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(elat));
    chk({tag, "/result"}, result, eres);
    chk({tag, "/br_taken"}, 32'(br_taken), 32'(ebr));
    chk({tag, "/illegal"}, 32'(illegal), 32'(eill));
  endtask

  task automatic op16(input string tag, input logic [3:0] sel, input logic [2:0] f3,
                      input logic [15:0] aa, input logic [15:0] bb, input logic [15:0] eres,
                      input logic eill, input int elat);
    int lat;
    alu_sel = sel; func3 = f3; a16 = aa; b16 = bb; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    lat = 1;
    while (!ov16 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), 32'(elat));
    chk({tag, "/result"}, 32'(r16), 32'(eres));
    chk({tag, "/illegal"}, 32'(ill16), 32'(eill));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; iv16 = 1'b0; out_ready = 1'b1;
    alu_sel = '0; func3 = '0; a = '0; b = '0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst/out_valid", 32'(out_valid), 32'd0);
    chk("rst/result", result, 32'd0);
    chk("rst/br_taken", 32'(br_taken), 32'd0);
    chk("rst/illegal", 32'(illegal), 32'd0);
    chk("rst/in_ready", 32'(in_ready), 32'd1);

    // Arithmetic, logic, shifts, compares
    op("add_wrap", 4'b0000, 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1);
    op("sub",      4'b0001, 3'b000, 32'h3, 32'h5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    op("sra",      4'b1010, 3'b000, 32'h8000_0000, 32'h4, 32'hF800_0000, 1'b0, 1'b0, 1);
    op("srl",      4'b1000, 3'b000, 32'h8000_0000, 32'h4, 32'h0800_0000, 1'b0, 1'b0, 1);
    op("sll_31",   4'b1001, 3'b000, 32'h1, 32'h3F, 32'h8000_0000, 1'b0, 1'b0, 1);
    op("sltu",     4'b1111, 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1);
    op("slt",      4'b1101, 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1);
    op("and",      4'b0101, 3'b000, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0, 1);
    op("or",       4'b0100, 3'b000, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0, 1'b0, 1);
    op("xor",      4'b0111, 3'b000, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0, 1'b0, 1);
    op("lui",      4'b0110, 3'b000, 32'h0, 32'h000A_BCDE, 32'hABCD_E000, 1'b0, 1'b0, 1);

    // Branches and jump
    op("br_ltu",   4'b0010, 3'b110, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1);
    op("br_lt",    4'b0010, 3'b100, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1);
    op("br_ge",    4'b0010, 3'b101, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1);
    op("br_geu",   4'b0010, 3'b111, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1);
    op("br_eq",    4'b0010, 3'b000, 32'h55, 32'h55, 32'h0, 1'b1, 1'b0, 1);
    op("br_ne",    4'b0010, 3'b001, 32'h55, 32'h55, 32'h0, 1'b0, 1'b0, 1);
    op("br_010",   4'b0010, 3'b010, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1);
    op("jump",     4'b0011, 3'b000, 32'h100, 32'h8, 32'h108, 1'b1, 1'b0, 1);
    op("bad_sel",  4'b1110, 3'b000, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1, 1);

`ifdef SEQ_ALU_MULDIV_EN
    op("mulh",     4'b1100, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 33);
    op("mulhu",    4'b1100, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 33);
    op("mul",      4'b1100, 3'b000, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 1'b0, 33);
    op("mulhsu",   4'b1100, 3'b010, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
    op("div",      4'b1100, 3'b100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 1'b0, 1'b0, 33);
    op("rem",      4'b1100, 3'b110, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
    op("divu",     4'b1100, 3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33);
    op("remu",     4'b1100, 3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 33);
    op("divu_z",   4'b1100, 3'b101, 32'h5, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    op("remu_z",   4'b1100, 3'b111, 32'h5, 32'h0, 32'h5, 1'b0, 1'b0, 1);
    op("div_ovf",  4'b1100, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1);
    op("rem_ovf",  4'b1100, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1);
`else
    op("md_off",   4'b1100, 3'b000, 32'h7, 32'h3, 32'h0, 1'b0, 1'b1, 1);
    op("md_off_d", 4'b1100, 3'b100, 32'h7, 32'h3, 32'h0, 1'b0, 1'b1, 1);
`endif

    // Backpressure: result held while out_ready low, then back-to-back accept
    @(posedge clk); #1;
    out_ready = 1'b0;
    alu_sel = 4'b0000; func3 = 3'b000; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    alu_sel = 4'b0001; a = 32'd10; b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      chk("hold/out_valid", 32'(out_valid), 32'd1);
      chk("hold/result", result, 32'd7);
      chk("hold/in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("release/in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("release/out_valid", 32'(out_valid), 32'd1);
    chk("release/result", result, 32'd9);

    // Reset while a result is pending
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("rst_done/out_valid", 32'(out_valid), 32'd0);
    chk("rst_done/result", result, 32'd0);
    chk("rst_done/in_ready", 32'(in_ready), 32'd1);

`ifdef SEQ_ALU_MULDIV_EN
    // Reset in the 10th CALC cycle of a divide discards it
    op("pre_t1", 4'b0000, 3'b000, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0, 1);
    alu_sel = 4'b1100; func3 = 3'b100; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t1/calc_in_ready", 32'(in_ready), 32'd0);
    chk("t1/calc_out_valid", 32'(out_valid), 32'd0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t1/out_valid", 32'(out_valid), 32'd0);
    chk("t1/result", result, 32'd0);
    chk("t1/in_ready", 32'(in_ready), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    chk("t1/discarded", 32'(out_valid), 32'd0);
`endif

    // XLEN=16 instance
    op16("x16_add",  4'b0000, 3'b000, 16'hFFFF, 16'h1, 16'h0, 1'b0, 1);
    op16("x16_sra",  4'b1010, 3'b000, 16'h8000, 16'h4, 16'hF800, 1'b0, 1);
    op16("x16_slt",  4'b1101, 3'b000, 16'hFFFF, 16'h1, 16'h1, 1'b0, 1);
    op16("x16_sltu", 4'b1111, 3'b000, 16'hFFFF, 16'h1, 16'h0, 1'b0, 1);
`ifdef SEQ_ALU_MULDIV_EN
    op16("x16_mulhu", 4'b1100, 3'b011, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 17);
    op16("x16_mul",   4'b1100, 3'b000, 16'h7, 16'hFFFD, 16'hFFEB, 1'b0, 17);
`else
    op16("x16_md",    4'b1100, 3'b001, 16'hFFFF, 16'hFFFF, 16'h0, 1'b1, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
